// File: rtl/beats_pkg.sv
// Shared types and constants for the drum bar player: bar layout, FSM states,
// one-hot beat markers.
package beats_pkg;

    localparam int BAR_W  = 8;
    localparam int HAND_W = 4;
    localparam int STEPS  = 4;

    typedef struct packed {
        logic [HAND_W-1:0] left;
        logic [HAND_W-1:0] right;
    } bar_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [3:0] BEAT_ONE   = 4'b1000;
    localparam logic [3:0] BEAT_TWO   = 4'b0100;
    localparam logic [3:0] BEAT_THREE = 4'b0010;
    localparam logic [3:0] BEAT_FOUR  = 4'b0001;

    // Step index to one-hot marker; also serves as the per-hand bit select.
    function automatic logic [3:0] beat_of(input logic [1:0] step);
        logic [3:0] b;
        case (step)
            2'd0:    b = BEAT_ONE;
            2'd1:    b = BEAT_TWO;
            2'd2:    b = BEAT_THREE;
            default: b = BEAT_FOUR;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/beats_player_if.sv
// Bar queue handshake between the pattern generator (master) and the player (slave).
interface beats_player_if;
    import beats_pkg::*;

    logic [BAR_W-1:0] bar_in;
    logic             bar_valid;
    logic             bar_ready;

    modport master (output bar_in, output bar_valid, input  bar_ready);
    modport slave  (input  bar_in, input  bar_valid, output bar_ready);

endinterface

// File: rtl/beats_tick_div.sv
// Tempo counter: counts 0..TICK_DIV-1 while enabled, held at zero by clr.
module beats_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick0,
    output logic tick_last
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
        end
    end

    assign tick0     = en && (cnt == '0);
    assign tick_last = en && (cnt == LAST);

endmodule

// File: rtl/beats_player.sv
// Drum bar player: one active + one queued bar, step strobes at TICK_DIV tempo.
// Build option BEATS_LOOP_EN: replay the active bar on underrun instead of stopping.
//
// state | meaning
// IDLE  | no playback; waits for start with a queued bar
// PLAY  | stepping through the active bar, one step per TICK_DIV cycles
module beats_player #(
    parameter int TICK_DIV = 4,
    parameter int STEPS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    beats_player_if.slave        bar,
    input  logic                 start,
    input  logic                 stop,
    output logic                 left_hit,
    output logic                 right_hit,
    output logic [3:0]           beat,
    output logic                 playing,
    output logic                 underrun
);
    import beats_pkg::*;

    state_t     state;
    bar_t       active;
    bar_t       shadow;
    logic       shadow_full;
    logic [1:0] step;
    logic       tick0;
    logic       tick_last;

    assign bar.bar_ready = !shadow_full;
    assign playing       = (state == PLAY);

    beats_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (state == PLAY),
        .clr      (stop || state != PLAY),
        .tick0    (tick0),
        .tick_last(tick_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active      <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            step        <= '0;
            left_hit    <= 1'b0;
            right_hit   <= 1'b0;
            beat        <= '0;
            underrun    <= 1'b0;
        end else begin
            left_hit  <= 1'b0;
            right_hit <= 1'b0;
            beat      <= '0;
            underrun  <= 1'b0;

            // Ready is low while full, so this never collides with a shadow move.
            if (bar.bar_valid && !shadow_full) begin
                shadow      <= bar_t'(bar.bar_in);
                shadow_full <= 1'b1;
            end

            if (stop) begin
                state  <= IDLE;
                active <= '0;
                step   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && shadow_full) begin
                            active      <= shadow;
                            shadow_full <= 1'b0;
                            step        <= '0;
                            state       <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick0) begin
                            left_hit  <= |(active.left  & beat_of(step));
                            right_hit <= |(active.right & beat_of(step));
                            beat      <= beat_of(step);
                        end
                        if (tick_last) begin
                            if (step == 2'(STEPS - 1)) begin
                                step <= '0;
                                if (shadow_full) begin
                                    active      <= shadow;
                                    shadow_full <= 1'b0;
                                end else begin
                                    underrun <= 1'b1;
`ifndef BEATS_LOOP_EN
                                    state  <= IDLE;
                                    active <= '0;
`endif
                                end
                            end else begin
                                step <= step + 2'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(beat));
    assert property (@(posedge clk) disable iff (rst) (32'(step) < STEPS) && (STEPS == beats_pkg::STEPS));

endmodule

// File: tb/tb_beats_player.sv
// Self-checking bench for beats_player: vector table of bars plus hand-written
// sequences for queueing, stop, mid-bar reset and empty-queue start.
module tb_beats_player;

    localparam int T = 4;

    typedef struct {
        logic [7:0] bar;
        logic [3:0] l;
        logic [3:0] r;
    } vec_t;

    typedef struct {
        int         cyc;
        logic       l;
        logic       r;
        logic [3:0] beat;
        logic       und;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       left_hit;
    logic       right_hit;
    logic [3:0] beat;
    logic       playing;
    logic       underrun;

    int  cyc = 0;
    int  t0  = 0;
    int  vectors = 0;
    int  miscompares = 0;
    ev_t exp_q[$];
    vec_t vec[6];

    beats_player_if bus();

    beats_player #(.TICK_DIV(T), .STEPS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bar      (bus),
        .start    (start),
        .stop     (stop),
        .left_hit (left_hit),
        .right_hit(right_hit),
        .beat     (beat),
        .playing  (playing),
        .underrun (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc - t0, got, exp);
        end
    endtask

    // Scoreboard: strobe events scheduled when stimulus is driven, checked every cycle.
    always @(negedge clk) begin
        ev_t e;
        e = '{cyc: cyc, l: 1'b0, r: 1'b0, beat: 4'b0, und: 1'b0};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_event at cycle %0d: event for cycle %0d never matched", cyc - t0, exp_q[0].cyc - t0);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        chk("strobes", {left_hit, right_hit, beat, underrun, 1'b0}, {e.l, e.r, e.beat, e.und, 1'b0});
    end

    task automatic at(input int c);
        while (cyc < t0 + c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input logic l, input logic r, input logic [3:0] b, input logic u);
        exp_q.push_back('{cyc: t0 + c, l: l, r: r, beat: b, und: u});
    endtask

    task automatic push_bar(input int c0, input logic [3:0] l, input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            push_ev(c0 + k * T, l[3-k], r[3-k], 4'b1000 >> k, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        t0 = cyc;
        chk("reset_ready", {7'b0, bus.bar_ready}, 8'd1);
        chk("reset_playing", {7'b0, playing}, 8'd0);
    endtask

    task automatic queue_bar(input int c, input logic [7:0] b);
        at(c);
        bus.bar_in    = b;
        bus.bar_valid = 1'b1;
        at(c + 1);
        bus.bar_valid = 1'b0;
    endtask

    task automatic pulse_start(input int c);
        at(c);
        start = 1'b1;
        at(c + 1);
        start = 1'b0;
    endtask

    task automatic pulse_stop(input int c);
        at(c);
        stop = 1'b1;
        at(c + 1);
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        bus.bar_in = '0;
        bus.bar_valid = 1'b0;

        vec[0] = '{bar: 8'b1010_0101, l: 4'b1010, r: 4'b0101};
        vec[1] = '{bar: 8'hF0,        l: 4'b1111, r: 4'b0000};
        vec[2] = '{bar: 8'h0F,        l: 4'b0000, r: 4'b1111};
        vec[3] = '{bar: 8'h3C,        l: 4'b0011, r: 4'b1100};
        vec[4] = '{bar: 8'h81,        l: 4'b1000, r: 4'b0001};
        vec[5] = '{bar: 8'h00,        l: 4'b0000, r: 4'b0000};

        // Single bar, no follow-up: four steps then underrun at the boundary.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            queue_bar(5, vec[i].bar);
            chk("ready_after_queue", {7'b0, bus.bar_ready}, 8'd0);
            pulse_start(10);
            chk("playing_after_start", {7'b0, playing}, 8'd1);
            push_bar(12, vec[i].l, vec[i].r);
            push_ev(27, 1'b0, 1'b0, 4'b0, 1'b1);
`ifdef BEATS_LOOP_EN
            push_bar(28, vec[i].l, vec[i].r);
            at(27);
            chk("loop_playing", {7'b0, playing}, 8'd1);
            pulse_stop(40);
            chk("loop_stopped", {7'b0, playing}, 8'd0);
            at(46);
`else
            at(26);
            chk("playing_last_step", {7'b0, playing}, 8'd1);
            at(27);
            chk("playing_at_underrun", {7'b0, playing}, 8'd0);
            at(36);
`endif
        end

        // Two bars back to back: no gap, no underrun, ready held low until A ends.
        do_reset();
        queue_bar(5, 8'hF0);
        pulse_start(10);
        push_bar(12, 4'b1111, 4'b0000);
        push_bar(28, 4'b0000, 4'b1111);
        chk("ready_before_b", {7'b0, bus.bar_ready}, 8'd1);
        queue_bar(12, 8'h0F);
        chk("ready_after_b", {7'b0, bus.bar_ready}, 8'd0);
        at(26);
        chk("ready_end_of_a", {7'b0, bus.bar_ready}, 8'd0);
        at(27);
        chk("ready_b_moved", {7'b0, bus.bar_ready}, 8'd1);
        chk("playing_into_b", {7'b0, playing}, 8'd1);
        pulse_stop(42);
        chk("playing_after_stop_b", {7'b0, playing}, 8'd0);
        at(48);

        // Stop mid-bar, then start+stop together, then a clean start of the retained bar.
        do_reset();
        queue_bar(5, 8'hFF);
        pulse_start(10);
        push_ev(12, 1'b1, 1'b1, 4'b1000, 1'b0);
        pulse_stop(14);
        chk("stop_playing", {7'b0, playing}, 8'd0);
        queue_bar(20, 8'h33);
        chk("ready_shadow_held", {7'b0, bus.bar_ready}, 8'd0);
        at(30);
        start = 1'b1;
        stop  = 1'b1;
        at(31);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", {7'b0, playing}, 8'd0);
        chk("start_stop_shadow", {7'b0, bus.bar_ready}, 8'd0);
        pulse_start(35);
        chk("restart_playing", {7'b0, playing}, 8'd1);
        push_ev(37, 1'b0, 1'b0, 4'b1000, 1'b0);
        pulse_stop(39);
        chk("restart_stopped", {7'b0, playing}, 8'd0);
        at(45);

        // Reset mid-bar discards the queued bar; a later start is ignored.
        do_reset();
        queue_bar(5, 8'hFF);
        pulse_start(10);
        push_ev(12, 1'b1, 1'b1, 4'b1000, 1'b0);
        push_ev(16, 1'b1, 1'b1, 4'b0100, 1'b0);
        queue_bar(12, 8'h3C);
        chk("ready_3c_queued", {7'b0, bus.bar_ready}, 8'd0);
        at(17);
        rst = 1'b1;
        at(18);
        rst = 1'b0;
        chk("midreset_ready", {7'b0, bus.bar_ready}, 8'd1);
        chk("midreset_playing", {7'b0, playing}, 8'd0);
        pulse_start(22);
        chk("midreset_start_ignored", {7'b0, playing}, 8'd0);
        at(35);

        // Start with an empty queue for 50 cycles.
        do_reset();
        at(5);
        start = 1'b1;
        for (int j = 1; j <= 50; j += 10) begin
            at(5 + j);
            chk("empty_start_playing", {7'b0, playing}, 8'd0);
        end
        start = 1'b0;
        at(60);

        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
